// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between instruction fetch and the memory stage.
// Define ARB_STARVE_GUARD_EN to add a forced fetch grant after STARVE_MAX denied cycles.
module mem_port_arbiter #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              flush,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_gnt,
  output logic              mem_rvalid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              stall_if
);

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_IF   = 2'd1,
    RESP_MEM  = 2'd2
  } resp_e;

  resp_e resp_q, resp_d;
  logic  force_if;

  if (STARVE_MAX < 1) begin : g_starve_max_check
    $error("mem_port_arbiter: STARVE_MAX must be at least 1");
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

  assign force_if = (starve_cnt_q == STARVE_W'(STARVE_MAX));

  // Counts cycles the fetch was shut out by the memory stage; any break in the streak clears it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req || flush || if_gnt) begin
      starve_cnt_d = '0;
    end else if (mem_gnt && (starve_cnt_q != STARVE_W'(STARVE_MAX))) begin
      starve_cnt_d = starve_cnt_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  assign mem_gnt  = mem_req & ~force_if;
  assign if_gnt   = if_req & ~flush & (~mem_req | force_if);
  assign stall_if = if_req & ~if_gnt;
  assign ram_en   = if_gnt | mem_gnt;
  assign ram_we   = mem_gnt & mem_we;

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    if (if_gnt) begin
      ram_addr = if_addr;
    end else if (mem_gnt) begin
      ram_addr  = mem_addr;
      ram_wdata = mem_wdata;
    end
  end

  // Remembers which requester owns the RAM read data arriving next cycle; stores expect nothing back.
  always_comb begin
    resp_d = RESP_NONE;
    if (if_gnt) begin
      resp_d = RESP_IF;
    end else if (mem_gnt && !mem_we) begin
      resp_d = RESP_MEM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q <= RESP_NONE;
    end else begin
      resp_q <= resp_d;
    end
  end

  assign if_rvalid  = (resp_q == RESP_IF) & ~flush;
  assign mem_rvalid = (resp_q == RESP_MEM);
  assign if_rdata   = if_rvalid  ? ram_rdata : '0;
  assign mem_rdata  = mem_rvalid ? ram_rdata : '0;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, default 7, RAM word-address width (matches PC width)
- DATA_W, default 32, data width
- STARVE_MAX, default 3, consecutive fetch-denied cycles before a forced fetch grant
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch read request
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_W  fetch read data
- flush  in  1  branch taken; discard fetch traffic
- mem_req  in  1  memory-stage request (LDR/STR)
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  ADDR_W  memory-stage address
- mem_wdata  in  DATA_W  store data
- mem_gnt  out  1  memory-stage request accepted this cycle
- mem_rvalid  out  1  load data valid
- mem_rdata  out  DATA_W  load data
- ram_en  out  1  RAM access enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after a read access
- stall_if  out  1  if_req & ~if_gnt

Function
REQ-003 At most one of if_gnt and mem_gnt SHALL be high in any cycle; both grants SHALL be combinational from the current-cycle requests.
REQ-004 mem_gnt SHALL be mem_req & ~force_if.
REQ-005 if_gnt SHALL be if_req & ~flush & (~mem_req | force_if).
REQ-006 ram_en SHALL be if_gnt | mem_gnt; ram_addr/ram_wdata SHALL come from the granted requester (0 when idle); ram_we SHALL be mem_gnt & mem_we.
REQ-007 A registered response tag resp_q SHALL have states NONE, IF and MEM. Next value: IF on if_gnt; MEM on mem_gnt & ~mem_we; otherwise NONE.
REQ-008 if_rvalid SHALL be (resp_q==IF) & ~flush; mem_rvalid SHALL be (resp_q==MEM). Read latency SHALL be exactly 1 cycle after the grant.
REQ-009 if_rdata and mem_rdata SHALL equal ram_rdata while their rvalid is high and 0 otherwise.
REQ-010 A store SHALL produce no rvalid. Back-to-back grants SHALL be sustainable every cycle without bubbles.
REQ-011 A flush asserted together with a pending IF response SHALL drop that response; a flush asserted together with if_req SHALL deny the fetch; mem traffic SHALL be unaffected by flush.
REQ-012 Starvation counter starve_cnt SHALL:
- increment, saturating at STARVE_MAX, each cycle with if_req & ~flush & mem_gnt
- clear on if_gnt, on ~if_req, or on flush
REQ-013 force_if SHALL be (starve_cnt == STARVE_MAX). A forced fetch grant SHALL stall mem_req for that one cycle (mem_gnt=0).

Reset
REQ-014 While rst_n is low: resp_q=NONE, starve_cnt=0, if_rvalid=mem_rvalid=0, both rdata=0; grants SHALL follow REQ-004/005 with force_if=0.
REQ-015 Reset asserted mid-transaction SHALL discard any pending response; no rvalid SHALL be issued for it after release.

Configuration
REQ-016 Macro ARB_STARVE_GUARD_EN:
- defined: REQ-012/013 apply
- undefined: starve_cnt is absent, force_if is tied to 0, and the memory stage has strict priority

Verification
REQ-017 if_req=1, addr=5, no mem_req -> if_gnt=1 same cycle; next cycle if_rvalid=1, if_rdata=RAM[5].
REQ-018 if_req and mem_req (load, addr 9) in the same cycle -> mem_gnt=1, if_gnt=0, stall_if=1; next cycle mem_rvalid=1, mem_rdata=RAM[9].
REQ-019 Store mem_addr=3, mem_wdata=0xDEADBEEF, then fetch addr 3 -> ram_we=1 for one cycle, no mem_rvalid; fetch returns 0xDEADBEEF.
REQ-020 Fetch granted, flush=1 in the following cycle -> if_rvalid=0; a concurrent mem load still returns mem_rvalid=1.
REQ-021 With ARB_STARVE_GUARD_EN, STARVE_MAX=3, mem_req and if_req held high -> mem_gnt for 3 cycles, if_gnt in the 4th, then the pattern repeats. Without the macro, if_gnt never asserts.
REQ-022 rst_n pulled low 1 cycle after a load grant -> mem_rvalid=0 through and after reset; resp_q=NONE.
